// File: rtl/wb_common_pkg.sv
// Shared Wishbone definitions: cycle-type and burst-extension codes, plus the
// state encoding of the burst slave FSM.
package wb_common_pkg;

  // Cycle type identifier (wb_cti_i)
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  // Burst type extension (wb_bte_i)
  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  // Slave FSM states; also presented on the dbg_state output
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  // Width of the wait-state counter (WAIT_STATES is at most 15)
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next-word-address generator for incrementing bursts. Only the low bits
// selected by the wrap size advance; linear bursts flag an overflow when
// stepping past the last word of the array.
module wb_burst_addr_gen
  import wb_common_pkg::*;
#(
  parameter int AIW = 4
) (
  input  logic [AIW-1:0] cur_adr,
  input  logic [1:0]     bte,
  output logic [AIW-1:0] next_adr,
  output logic           ovf
);

  logic [AIW-1:0] inc_adr;
  logic [AIW-1:0] wrap_mask;

  // Select which address bits may change, then merge the incremented bits in
  always_comb begin
    inc_adr   = cur_adr + AIW'(1);
    wrap_mask = '1;
    ovf       = 1'b0;
    case (bte)
      BTE_LINEAR: begin
        wrap_mask = '1;
        ovf       = (cur_adr == '1);
      end
      BTE_WRAP4:  wrap_mask = AIW'(3);
      BTE_WRAP8:  wrap_mask = AIW'(7);
      BTE_WRAP16: wrap_mask = AIW'(15);
      default:    wrap_mask = '1;
    endcase
    next_adr = (cur_adr & ~wrap_mask) | (inc_adr & wrap_mask);
  end

endmodule

// File: rtl/wb_burst_slave_mem.sv
// Wishbone B4 register-array slave with classic and incrementing-burst
// support, programmable wait states before the first beat, and error
// termination for misaligned accesses and linear bursts running off the end.
//
// Handshake: a beat completes on a cycle where cyc and stb are high and the
// FSM is in ACK or BURST; that cycle carries exactly one of ack/err, both
// combinationally gated by cyc/stb so a dropped strobe or cycle suppresses
// termination immediately. Read data is driven only on acked beats.
module wb_burst_slave_mem
  import wb_common_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic [1:0]      dbg_state
);

  localparam int LB  = $clog2(DW/8);
  localparam int MB  = (LB == 0) ? 1 : LB;
  localparam int AIW = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [AIW-1:0]        adr_q, adr_d;
  logic                  mis_q, mis_d;
  logic                  ovf_q, ovf_d;
  logic [DW-1:0]         mem [DEPTH];

  logic [AIW-1:0] adr_idx;
  logic           adr_mis;
  logic [AIW-1:0] gen_next;
  logic           gen_ovf;
  logic           beat;
  logic           beat_err;
  logic           mem_we;
  logic           unused_adr;

  assign adr_idx    = wb_adr_i[LB+AIW-1:LB];
  assign adr_mis    = (LB == 0) ? 1'b0 : |wb_adr_i[MB-1:0];
  assign unused_adr = ^wb_adr_i;

  wb_burst_addr_gen #(
    .AIW (AIW)
  ) u_addr_gen (
    .cur_adr  (adr_q),
    .bte      (wb_bte_i),
    .next_adr (gen_next),
    .ovf      (gen_ovf)
  );

  // Termination and read-data decode from the registered beat context
  always_comb begin
    beat     = wb_cyc_i & wb_stb_i & ((state_q == ST_ACK) | (state_q == ST_BURST));
    beat_err = mis_q | ovf_q;
    wb_ack_o = beat & ~beat_err;
    wb_err_o = beat & beat_err;
    wb_rty_o = 1'b0;
    mem_we   = wb_ack_o & wb_we_i;
    wb_dat_o = wb_ack_o ? mem[adr_q] : '0;
    dbg_state = state_q;
  end

  // Next-state logic: capture the access in IDLE, count wait states, then
  // terminate once (classic) or every strobed cycle (incrementing burst)
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    adr_d   = adr_q;
    mis_d   = mis_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = adr_idx;
          mis_d   = adr_mis;
          ovf_d   = 1'b0;
          wait_d  = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ACK;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_ACK, ST_BURST: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wb_stb_i) begin
          if (wb_cti_i == CTI_INCR) begin
            state_d = ST_BURST;
            adr_d   = gen_next;
            ovf_d   = ovf_q | gen_ovf;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and beat-context registers
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      adr_q   <= '0;
      mis_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      adr_q   <= adr_d;
      mis_q   <= mis_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage: byte-lane masked writes on acked write beats only
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wb_sel_i[b]) mem[adr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule
